// File: rtl/mult_pipe_if.sv
// Operation encodings and the issue/writeback bundle of the pipelined multiplier.
// Request, flush and result signals share one interface; clock and reset stay scalar.
package mult_pipe_pkg;
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_MUL    = 4'd1,
        OP_MULH   = 4'd2,
        OP_MULHU  = 4'd3,
        OP_MULHSU = 4'd4,
        OP_MULW   = 4'd5
    } fu_op;
endpackage

interface mult_pipe_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned NUM_THREADS   = 2
);
    localparam int unsigned TW = $clog2(NUM_THREADS);

    logic                     valid_i;
    logic                     ready_o;
    mult_pipe_pkg::fu_op      op_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic [TW-1:0]            thread_id_i;
    logic                     flush_i;
    logic [TW-1:0]            flush_thread_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [XLEN-1:0]          result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    logic [TW-1:0]            thread_id_o;
    logic                     busy_o;

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, thread_id_i,
        input  flush_i, flush_thread_i, ready_i,
        output ready_o, valid_o, result_o, trans_id_o, thread_id_o, busy_o
    );

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, thread_id_i,
        output flush_i, flush_thread_i, ready_i,
        input  ready_o, valid_o, result_o, trans_id_o, thread_id_o, busy_o
    );
endinterface

// File: rtl/mult_pipe.sv
// Multi-thread integer multiplier: product formed at stage 0, STAGES elastic retiming
// registers with per-stage valid/ready, per-thread flush, in-order results.
module mult_pipe #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned STAGES        = 2,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned NUM_THREADS   = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mult_pipe_if.slave   bus
);
    import mult_pipe_pkg::*;

    localparam int unsigned TW   = $clog2(NUM_THREADS);
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0]        v_q, v_d;
    fu_op                     op_q   [STAGES];
    fu_op                     op_d   [STAGES];
    logic [TRANS_ID_BITS-1:0] tid_q  [STAGES];
    logic [TRANS_ID_BITS-1:0] tid_d  [STAGES];
    logic [TW-1:0]            thr_q  [STAGES];
    logic [TW-1:0]            thr_d  [STAGES];
    logic [2*XLEN-1:0]        prod_q [STAGES];
    logic [2*XLEN-1:0]        prod_d [STAGES];

    logic [STAGES-1:0] flush_hit_s;
    logic [STAGES-1:0] v_eff_s;
    logic [STAGES-1:0] adv_s;
    logic              is_mul_s;
    logic              sign_a_s;
    logic              sign_b_s;
    logic              in_flushed_s;
    logic [2*XLEN-1:0] a_wide_s;
    logic [2*XLEN-1:0] b_wide_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_last_s;
    logic [XLEN-1:0]   mulw_s;
    logic [XLEN-1:0]   result_s;

    // Operand decode: which ops multiply and how each operand is extended.
    always_comb begin
        is_mul_s = 1'b0;
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (bus.op_i)
            OP_MUL:    is_mul_s = 1'b1;
            OP_MULW:   is_mul_s = 1'b1;
            OP_MULHU:  is_mul_s = 1'b1;
            OP_MULH: begin
                is_mul_s = 1'b1;
                sign_a_s = 1'b1;
                sign_b_s = 1'b1;
            end
            OP_MULHSU: begin
                is_mul_s = 1'b1;
                sign_a_s = 1'b1;
            end
            default: is_mul_s = 1'b0;
        endcase
    end

    // Extending to 2*XLEN and multiplying modulo 2^(2*XLEN) equals the signed product truncated.
    assign a_wide_s = {{XLEN{bus.operand_a_i[XLEN-1] & sign_a_s}}, bus.operand_a_i};
    assign b_wide_s = {{XLEN{bus.operand_b_i[XLEN-1] & sign_b_s}}, bus.operand_b_i};
    assign prod_s   = a_wide_s * b_wide_s;

    assign in_flushed_s = bus.flush_i & (bus.thread_id_i == bus.flush_thread_i);

    // Flush matches per stage; a flushed last stage is treated as empty for the ready chain.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            flush_hit_s[k] = bus.flush_i & v_q[k] & (thr_q[k] == bus.flush_thread_i);
        end
        v_eff_s       = v_q;
        v_eff_s[LAST] = v_q[LAST] & ~flush_hit_s[LAST];
    end

    // Ready chain from writeback back to stage 0; independent of valid_i.
    always_comb begin
        logic chain_s;
        chain_s = bus.ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_s  = chain_s | ~v_eff_s[k];
            adv_s[k] = chain_s;
        end
    end

    // Next-state of every stage: load from upstream on advance, otherwise hold minus flushed valids.
    always_comb begin
        v_d    = v_q & ~flush_hit_s;
        op_d   = op_q;
        tid_d  = tid_q;
        thr_d  = thr_q;
        prod_d = prod_q;
        if (adv_s[0]) begin
            v_d[0]    = bus.valid_i & is_mul_s & ~in_flushed_s;
            op_d[0]   = bus.op_i;
            tid_d[0]  = bus.trans_id_i;
            thr_d[0]  = bus.thread_id_i;
            prod_d[0] = prod_s;
        end else begin
            v_d[0]    = v_q[0] & ~flush_hit_s[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv_s[k]) begin
                v_d[k]    = v_q[k-1] & ~flush_hit_s[k-1];
                op_d[k]   = op_q[k-1];
                tid_d[k]  = tid_q[k-1];
                thr_d[k]  = thr_q[k-1];
                prod_d[k] = prod_q[k-1];
            end else begin
                v_d[k]    = v_q[k] & ~flush_hit_s[k];
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]   <= OP_ADD;
                tid_q[k]  <= '0;
                thr_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]   <= op_d[k];
                tid_q[k]  <= tid_d[k];
                thr_q[k]  <= thr_d[k];
                prod_q[k] <= prod_d[k];
            end
        end
    end

    assign prod_last_s = prod_q[LAST];

    generate
        if (XLEN == 64) begin : g_mulw64
            assign mulw_s = {{(XLEN-32){prod_last_s[31]}}, prod_last_s[31:0]};
        end else begin : g_mulw32
            assign mulw_s = prod_last_s[XLEN-1:0];
        end
    endgenerate

    // Result select from the last stage.
    always_comb begin
        result_s = prod_last_s[XLEN-1:0];
        case (op_q[LAST])
            OP_MULH:   result_s = prod_last_s[2*XLEN-1:XLEN];
            OP_MULHU:  result_s = prod_last_s[2*XLEN-1:XLEN];
            OP_MULHSU: result_s = prod_last_s[2*XLEN-1:XLEN];
            OP_MULW:   result_s = mulw_s;
            default:   result_s = prod_last_s[XLEN-1:0];
        endcase
    end

    assign bus.ready_o     = adv_s[0];
    assign bus.valid_o     = v_eff_s[LAST];
    assign bus.result_o    = result_s;
    assign bus.trans_id_o  = tid_q[LAST];
    assign bus.thread_id_o = thr_q[LAST];
    assign bus.busy_o      = |v_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: expected results are queued on accept and
// compared in order on every output handshake.
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STAGES = 2;

    logic clk;
    logic rst_ni;

    mult_pipe_if #(.XLEN(XLEN), .TRANS_ID_BITS(3), .NUM_THREADS(2)) bus ();

    mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TRANS_ID_BITS(3), .NUM_THREADS(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  tid;
        logic        th;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_mul(input fu_op op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU) ||
               (op == OP_MULHSU) || (op == OP_MULW);
    endfunction

    function automatic logic [63:0] model(input fu_op op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic [31:0]         w;
        case (op)
            OP_MUL:    return a * b;
            OP_MULH: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return sp[127:64];
            end
            OP_MULHU: begin
                up = {64'd0, a} * {64'd0, b};
                return up[127:64];
            end
            OP_MULHSU: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                return sp[127:64];
            end
            OP_MULW: begin
                w = a[31:0] * b[31:0];
                return {{32{w[31]}}, w};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Monitor: pop on output handshake, drop flushed entries, push on accept.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 64'(bus.result_o), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("result", bus.result_o, e.res);
                    check_eq("trans_id", 64'(bus.trans_id_o), 64'(e.tid));
                    check_eq("thread_id", 64'(bus.thread_id_o), 64'(e.th));
                end
            end
            if (bus.flush_i) begin
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].th == bus.flush_thread_i) sb.delete(i);
                end
            end
            if (bus.valid_i && bus.ready_o && is_mul(bus.op_i) &&
                !(bus.flush_i && (bus.thread_id_i == bus.flush_thread_i))) begin
                exp_t e;
                e.res = model(bus.op_i, bus.operand_a_i, bus.operand_b_i);
                e.tid = bus.trans_id_i;
                e.th  = bus.thread_id_i;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] tid, input logic th);
        int n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.trans_id_i  = tid;
        bus.thread_id_i = th;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bus.valid_i = 1'b0;
        if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_ni             = 1'b0;
        bus.valid_i        = 1'b0;
        bus.op_i           = OP_ADD;
        bus.operand_a_i    = 64'd0;
        bus.operand_b_i    = 64'd0;
        bus.trans_id_i     = 3'd0;
        bus.thread_id_i    = 1'b0;
        bus.flush_i        = 1'b0;
        bus.flush_thread_i = 1'b0;
        bus.ready_i        = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(bus.valid_o), 64'd0);
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_ready", 64'(bus.ready_o), 64'd1);
        check_eq("rst_result", bus.result_o, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Latency: MUL 3*5, valid_o appears exactly STAGES cycles after accept.
        send(OP_MUL, 64'd3, 64'd5, 3'd5, 1'b1);
        @(negedge clk);
        check_eq("lat_early", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        check_eq("lat_valid", 64'(bus.valid_o), 64'd1);
        check_eq("lat_result", bus.result_o, 64'd15);
        wait_drain();

        // Arithmetic corner cases streamed back to back.
        send(OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        send(OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b1);
        send(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   3'd3, 1'b0);
        send(OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2,                   3'd4, 1'b1);
        send(OP_MUL,    64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 3'd6, 1'b0);
        send(OP_MULHSU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 1'b1);
        wait_drain();

        // Backpressure: writeback stalls for 4 cycles while 5 ops are offered.
        bus.ready_i = 1'b0;
        send(OP_MUL, 64'd7, 64'd11, 3'd0, 1'b0);
        send(OP_MUL, 64'd13, 64'd17, 3'd1, 1'b1);
        fork
            begin
                send(OP_MULHU, 64'hF000_0000_0000_0001, 64'd16, 3'd2, 1'b0);
                send(OP_MUL,   64'd19, 64'd23, 3'd3, 1'b1);
                send(OP_MULW,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'd4, 1'b0);
            end
            begin
                @(negedge clk);
                check_eq("bp_ready_low", 64'(bus.ready_o), 64'd0);
                check_eq("bp_valid", 64'(bus.valid_o), 64'd1);
                check_eq("bp_hold0", bus.result_o, 64'd77);
                @(negedge clk);
                check_eq("bp_hold1", bus.result_o, 64'd77);
                check_eq("bp_tid_hold", 64'(bus.trans_id_o), 64'd0);
                @(posedge clk);
                #1;
                bus.ready_i = 1'b1;
            end
        join
        wait_drain();

        // Flush thread 1 while its op sits in the last stage with ready_i high.
        send(OP_MUL, 64'd2, 64'd3, 3'd1, 1'b0);
        send(OP_MUL, 64'd4, 64'd5, 3'd2, 1'b1);
        send(OP_MUL, 64'd6, 64'd7, 3'd3, 1'b0);
        bus.flush_i        = 1'b1;
        bus.flush_thread_i = 1'b1;
        @(negedge clk);
        check_eq("flush_mask", 64'(bus.valid_o), 64'd0);
        check_eq("flush_busy", 64'(bus.busy_o), 64'd1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        wait_drain();

        // Input of the flushed thread accepted in the flush cycle enters invalid.
        bus.flush_i        = 1'b1;
        bus.flush_thread_i = 1'b1;
        send(OP_MUL, 64'd9, 64'd9, 3'd5, 1'b1);
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("flush_in_busy", 64'(bus.busy_o), 64'd0);

        // Non-multiply encodings are accepted but vanish.
        bus.valid_i = 1'b1;
        bus.op_i    = OP_ADD;
        @(negedge clk);
        check_eq("nonmul_ready", 64'(bus.ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.op_i = fu_op'(4'd9);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("nonmul_busy", 64'(bus.busy_o), 64'd0);
            check_eq("nonmul_valid", 64'(bus.valid_o), 64'd0);
        end

        // Reset with two ops in flight.
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        send(OP_MUL, 64'd21, 64'd2, 3'd6, 1'b0);
        send(OP_MUL, 64'd22, 64'd2, 3'd7, 1'b1);
        check_eq("pre_rst_busy", 64'(bus.busy_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("rst_mid_valid", 64'(bus.valid_o), 64'd0);
        check_eq("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        sb.delete();
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("post_rst_valid", 64'(bus.valid_o), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
